// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit opcode encodings and the shift-kind select.
// The shift kind is only consumed when ALU_SHIFT_EN is defined.
package alu_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10
  } shift_kind_e;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for SLL/SRL/SRA. The module only exists when ALU_SHIFT_EN
// is defined, so a build without the macro carries no shifter at all.
`ifdef ALU_SHIFT_EN
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_kind_e        kind,
  output logic [WIDTH-1:0]   shifted
);

  always_comb begin
    shifted = a;
    case (kind)
      SH_SLL:  shifted = a << shamt;
      SH_SRL:  shifted = a >> shamt;
      SH_SRA:  shifted = $signed(a) >>> shamt;
      default: shifted = a;
    endcase
  end

endmodule
`endif

// File: rtl/alu.sv
// Combinational ALU with a registered copy of result/zero.
// Define ALU_SHIFT_EN to enable SLL/SRL/SRA; otherwise those opcodes decode as undefined (result 0).
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q
);

  logic [WIDTH-1:0] w_result;
  logic             w_slt;
  logic             w_sltu;
  logic [WIDTH-1:0] r_result_q;
  logic             r_zero_q;

  assign w_slt  = $signed(a) < $signed(b);
  assign w_sltu = a < b;

`ifdef ALU_SHIFT_EN
  shift_kind_e      w_shift_kind;
  logic [WIDTH-1:0] w_shifted;

  always_comb begin
    w_shift_kind = SH_SLL;
    case (alu_op)
      ALU_SRL: w_shift_kind = SH_SRL;
      ALU_SRA: w_shift_kind = SH_SRA;
      default: w_shift_kind = SH_SLL;
    endcase
  end

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .a       (a),
    .shamt   (b[SHAMT_W-1:0]),
    .kind    (w_shift_kind),
    .shifted (w_shifted)
  );
`endif

  // Any opcode not listed (including shifts when disabled) yields zero.
  always_comb begin
    w_result = '0;
    case (alu_op)
      ALU_ADD:  w_result = a + b;
      ALU_SUB:  w_result = a - b;
      ALU_AND:  w_result = a & b;
      ALU_OR:   w_result = a | b;
      ALU_XOR:  w_result = a ^ b;
      ALU_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
      ALU_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_sltu};
`ifdef ALU_SHIFT_EN
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  w_result = w_shifted;
`endif
      default:  w_result = '0;
    endcase
  end

  assign result = w_result;
  assign zero   = (w_result == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result_q <= '0;
      r_zero_q   <= 1'b1;
    end else begin
      r_result_q <= w_result;
      r_zero_q   <= (w_result == '0);
    end
  end

  assign result_q = r_result_q;
  assign zero_q   = r_zero_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: combinational and registered outputs checked against hand-computed vectors.
// Shift expectations follow ALU_SHIFT_EN, matching however the design was built.
module tb_alu;
  import alu_pkg::*;

  localparam int WIDTH = 32;
`ifdef ALU_SHIFT_EN
  localparam bit SHIFT_ON = 1'b1;
`else
  localparam bit SHIFT_ON = 1'b0;
`endif

  typedef struct {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             z;
  } vec_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t            vecs[$];
  logic [WIDTH:0]  exp_q[$];

  alu #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .alu_op   (alu_op),
    .result   (result),
    .zero     (zero),
    .result_q (result_q),
    .zero_q   (zero_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic [WIDTH-1:0] res, input logic z);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.res = res; v.z = z;
    vecs.push_back(v);
  endtask

  // drive one vector, check combinational outputs, then the registered copy after the edge
  task automatic apply_vec(input int idx, input vec_t v);
    logic [WIDTH:0] e;
    @(negedge clk);
    alu_op = v.op;
    a      = v.a;
    b      = v.b;
    #1;
    check($sformatf("v%0d_result", idx), result, v.res);
    check($sformatf("v%0d_zero", idx), {31'd0, zero}, {31'd0, v.z});
    exp_q.push_back({v.z, v.res});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("v%0d_result_q", idx), result_q, e[WIDTH-1:0]);
    check($sformatf("v%0d_zero_q", idx), {31'd0, zero_q}, {31'd0, e[WIDTH]});
  endtask

  initial begin
    rst    = 1'b1;
    a      = '0;
    b      = '0;
    alu_op = ALU_ADD;

    add_vec(ALU_ADD,  32'd15, 32'd10, 32'd25, 1'b0);
    add_vec(ALU_SUB,  32'd20, 32'd10, 32'd10, 1'b0);
    add_vec(ALU_SUB,  32'd7,  32'd7,  32'd0,  1'b1);
    add_vec(ALU_AND,  32'd12, 32'd7,  32'd4,  1'b0);
    add_vec(ALU_OR,   32'd5,  32'd3,  32'd7,  1'b0);
    add_vec(ALU_XOR,  32'd5,  32'd3,  32'd6,  1'b0);
    add_vec(ALU_SLT,  32'd5,  32'd7,  32'd1,  1'b0);
    add_vec(ALU_SLT,  32'd7,  32'd5,  32'd0,  1'b1);
    add_vec(ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    add_vec(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    add_vec(ALU_ADD,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    add_vec(ALU_SUB,  32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    add_vec(ALU_SLT,  32'h8000_0000, 32'd0, 32'd1, 1'b0);
    add_vec(ALU_SLTU, 32'h8000_0000, 32'd0, 32'd0, 1'b1);
    add_vec(ALU_SLTU, 32'd3, 32'h8000_0000, 32'd1, 1'b0);
    add_vec(ALU_SLL,  32'd1, 32'd31, SHIFT_ON ? 32'h8000_0000 : 32'd0, !SHIFT_ON);
    add_vec(ALU_SRA,  32'h8000_0000, 32'd4, SHIFT_ON ? 32'hF800_0000 : 32'd0, !SHIFT_ON);
    add_vec(ALU_SRL,  32'h8000_0000, 32'd4, SHIFT_ON ? 32'h0800_0000 : 32'd0, !SHIFT_ON);
    add_vec(ALU_SRL,  32'h8000_0000, 32'h0000_0024, SHIFT_ON ? 32'h0800_0000 : 32'd0, !SHIFT_ON);
    add_vec(ALU_SLL,  32'h0000_1234, 32'h0000_0020, SHIFT_ON ? 32'h0000_1234 : 32'd0, !SHIFT_ON);
    add_vec(ALU_SRA,  32'h4000_0000, 32'd1, SHIFT_ON ? 32'h2000_0000 : 32'd0, !SHIFT_ON);
    add_vec(4'b1111,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
    add_vec(4'b1010,  32'd1, 32'd2, 32'd0, 1'b1);

    // reset holds the registers regardless of clock and leaves the combinational path alone
    #3;
    check("rst_result_q", result_q, 32'd0);
    check("rst_zero_q", {31'd0, zero_q}, 32'd1);
    a      = 32'd15;
    b      = 32'd10;
    alu_op = ALU_ADD;
    #1;
    check("rst_comb_result", result, 32'd25);
    check("rst_comb_zero", {31'd0, zero}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_result_q", result_q, 32'd0);
    check("rst_hold_zero_q", {31'd0, zero_q}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // mid-cycle reset with result_q = 25, then recovery on the next edge
    @(negedge clk);
    alu_op = ALU_ADD;
    a      = 32'd15;
    b      = 32'd10;
    @(posedge clk);
    #1;
    check("pre_rst_result_q", result_q, 32'd25);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_result_q", result_q, 32'd0);
    check("mid_rst_zero_q", {31'd0, zero_q}, 32'd1);
    check("mid_rst_comb_result", result, 32'd25);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_hold_q", result_q, 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_result_q", result_q, 32'd25);
    check("post_rst_zero_q", {31'd0, zero_q}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result bit width; all requirements below use WIDTH=32.
REQ-002 clk  input  1  single clock; all registered state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a  input  WIDTH  operand A.
REQ-005 b  input  WIDTH  operand B; shift amount is b[4:0] for shift ops.
REQ-006 alu_op  input  4  operation select.
REQ-007 result  output  WIDTH  combinational operation result.
REQ-008 zero  output  1  combinational flag, 1 when result == 0.
REQ-009 result_q  output  WIDTH  registered copy of result.
REQ-010 zero_q  output  1  registered copy of zero.

Function
REQ-011 alu_op 0000 ADD: result SHALL be a+b modulo 2^WIDTH; carry discarded.
REQ-012 alu_op 0001 SUB: result SHALL be a-b modulo 2^WIDTH; borrow discarded.
REQ-013 alu_op 0010 AND, 0011 OR, 0100 XOR: result SHALL be the bitwise operation.
REQ-014 alu_op 0101 SLT: result SHALL be 1 if signed(a) < signed(b), else 0; upper bits 0.
REQ-015 alu_op 0110 SLTU: result SHALL be 1 if unsigned(a) < unsigned(b), else 0.
REQ-016 alu_op 0111 SLL, 1000 SRL (zero fill), 1001 SRA (sign fill): shift a by b[4:0]; upper bits of b ignored; shift of 0 returns a.
REQ-017 alu_op 1010..1111 (undefined): result SHALL be 0, so zero=1.
REQ-018 result and zero SHALL be purely combinational, zero-cycle latency, valid within the same cycle as input change.
REQ-019 zero SHALL be 1 exactly when all result bits are 0, for every opcode including SLT/SLTU.
REQ-020 result_q/zero_q SHALL capture result/zero on every rising clk edge when rst is low; one-cycle latency, no enable or handshake.
REQ-021 Boundary: ADD 0xFFFFFFFF+1 -> 0, zero=1; SUB 0-1 -> 0xFFFFFFFF; SLT 0x80000000 vs 0 -> 1; SLTU same -> 0.

Reset
REQ-022 While rst is high, result_q SHALL be 0 and zero_q SHALL be 1, asynchronously, regardless of clk.
REQ-023 rst SHALL NOT affect combinational result/zero.
REQ-024 First rising edge with rst low SHALL load current result/zero into result_q/zero_q.

Configuration
REQ-025 Macro ALU_SHIFT_EN: when defined, SLL/SRL/SRA SHALL be implemented per REQ-016.
REQ-026 When ALU_SHIFT_EN is not defined, opcodes 0111/1000/1001 SHALL behave as undefined opcodes (result 0, zero 1) and no shifter logic SHALL be instantiated.

Structure
REQ-027 Package alu_pkg SHALL hold the 4-bit opcode constants (ALU_ADD..ALU_SRA) and an alu_op enum/typedef; module and bench SHALL use them.
REQ-028 Shifting SHALL be in sub-module alu_shifter (inputs a, shamt[4:0], 2-bit shift kind; output shifted value), instantiated only under ALU_SHIFT_EN.
REQ-029 Opcode decode SHALL be a single combinational case with default branch producing 0.

Verification
REQ-030 ADD a=15, b=10 -> result=25, zero=0; SUB a=20, b=10 -> result=10, zero=0; SUB a=7, b=7 -> result=0, zero=1.
REQ-031 AND a=12, b=7 -> 4; OR a=5, b=3 -> 7; XOR a=5, b=3 -> 6; all zero=0.
REQ-032 SLT a=5, b=7 -> 1; SLT a=0xFFFFFFFF(-1), b=1 -> 1; SLTU same operands -> 0, zero=1.
REQ-033 With ALU_SHIFT_EN: SLL a=1, b=31 -> 0x80000000; SRA a=0x80000000, b=4 -> 0xF8000000; SRL same -> 0x08000000; without macro all three -> 0, zero=1.
REQ-034 rst asserted mid-cycle with result_q=25 -> result_q=0, zero_q=1 immediately; deassert, ADD 15+10, next rising edge -> result_q=25, zero_q=0.
REQ-035 alu_op=1111, a=b=0xFFFFFFFF -> result=0, zero=1.
